// File: rtl/pc_gen_way0.sv
// Way-0 fetch program-counter generator: issues sequential fetch addresses,
// tracks in-flight requests and marks responses to pre-jump requests as stale.
module pc_gen_way0 #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter logic [31:0] PC_STEP         = 32'd8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ready_i,
    input  logic        dataOk_i,
    input  logic        jumpFlag_i,
    input  logic [31:0] jumpAddr_i,
    output logic        valid_o,
    output logic [31:0] instAddr_o,
    output logic        respValid_o,
    output logic        flush_o,
    output logic        misaligned_o,
    output logic [2:0]  outstanding_o
);

    typedef enum logic [1:0] {BOOT, RUN, FULL, DRAIN} state_e;

    localparam logic [2:0] MAX = 3'(MAX_OUTSTANDING);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  out_q, out_d;
    logic [2:0]  drop_q, drop_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;
    logic        fire, dec;
    logic [2:0]  out_nxt;

    assign valid_o       = (state_q == RUN) && (out_q < MAX);
    assign instAddr_o    = addr_q;
    assign respValid_o   = dataOk_i && (out_q != '0) && (drop_q == '0);
    assign flush_o       = flush_q;
    assign misaligned_o  = mis_q;
    assign outstanding_o = out_q;

    assign fire    = valid_o & ready_i;
    assign dec     = dataOk_i & (out_q != '0);
    assign out_nxt = out_q + {2'b00, fire} - {2'b00, dec};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        out_d   = out_nxt;
        drop_d  = drop_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, FULL: begin
                if (fire) addr_d = addr_q + PC_STEP;
                state_d = (out_nxt >= MAX) ? FULL : RUN;
            end
            DRAIN: begin
                drop_d  = drop_q - {2'b00, dec};
                state_d = (drop_d == '0) ? RUN : DRAIN;
            end
            default: state_d = BOOT;
        endcase

        // A jump overrides sequential advance; a same-cycle fire is already
        // counted in out_nxt and therefore lands in the drop count too.
        if (jumpFlag_i) begin
            addr_d  = {jumpAddr_i[31:2], 2'b00};
            flush_d = 1'b1;
            mis_d   = |jumpAddr_i[1:0];
            if (state_q == RUN || state_q == FULL) begin
                drop_d  = out_nxt;
                state_d = (out_nxt != '0) ? DRAIN : RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            addr_q  <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_way0.sv
// Scoreboard bench for pc_gen_way0: a queue of live/stale tags per issued
// request is popped and compared against respValid_o on every dataOk_i.
module tb_pc_gen_way0;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned MAXO     = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ready_i = 1'b0;
    logic        dataOk_i = 1'b0;
    logic        jumpFlag_i = 1'b0;
    logic [31:0] jumpAddr_i = '0;
    logic        valid_o;
    logic [31:0] instAddr_o;
    logic        respValid_o;
    logic        flush_o;
    logic        misaligned_o;
    logic [2:0]  outstanding_o;

    pc_gen_way0 #(
        .RESET_PC(RESET_PC),
        .PC_STEP(32'd8),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ready_i(ready_i),
        .dataOk_i(dataOk_i),
        .jumpFlag_i(jumpFlag_i),
        .jumpAddr_i(jumpAddr_i),
        .valid_o(valid_o),
        .instAddr_o(instAddr_o),
        .respValid_o(respValid_o),
        .flush_o(flush_o),
        .misaligned_o(misaligned_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] model_pc;
    bit          model_boot;
    bit          exp_flush, exp_mis;
    bit          live_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Entered and left at a falling clock edge; one rising edge per call.
    task automatic step(input bit rdy, input bit dok, input bit jmp, input logic [31:0] ja);
        int unsigned stale;
        bit          exp_valid, fire, exp_r;
        ready_i    = rdy;
        dataOk_i   = dok;
        jumpFlag_i = jmp;
        jumpAddr_i = ja;
        #1;
        stale = 0;
        for (int i = 0; i < live_q.size(); i++) if (!live_q[i]) stale++;
        exp_valid = !model_boot && stale == 0 && live_q.size() < MAXO;

        check_eq("flush", {31'd0, flush_o}, {31'd0, exp_flush});
        check_eq("misaligned", {31'd0, misaligned_o}, {31'd0, exp_mis});
        check_eq("outstanding", {29'd0, outstanding_o}, 32'(live_q.size()));
        check_eq("valid", {31'd0, valid_o}, {31'd0, exp_valid});
        if (exp_valid) check_eq("addr", instAddr_o, model_pc);

        fire  = exp_valid && rdy;
        exp_r = 1'b0;
        if (dok && live_q.size() > 0) exp_r = live_q.pop_front();
        check_eq("respValid", {31'd0, respValid_o}, {31'd0, exp_r});
        if (fire) live_q.push_back(1'b1);

        if (jmp) begin
            for (int i = 0; i < live_q.size(); i++) live_q[i] = 1'b0;
            model_pc = {ja[31:2], 2'b00};
        end else if (fire) begin
            model_pc = model_pc + 32'd8;
        end
        exp_flush = jmp;
        exp_mis   = jmp && (ja[1:0] != 2'b00);

        @(negedge clk);
        model_boot = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ready_i    = 1'b0;
        jumpFlag_i = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_addr", instAddr_o, RESET_PC);
        check_eq("rst_resp", {31'd0, respValid_o}, 32'd0);
        check_eq("rst_flush", {31'd0, flush_o}, 32'd0);
        check_eq("rst_mis", {31'd0, misaligned_o}, 32'd0);
        check_eq("rst_out", {29'd0, outstanding_o}, 32'd0);
        dataOk_i = 1'b0;
        live_q.delete();
        model_pc   = RESET_PC;
        model_boot = 1'b1;
        exp_flush  = 1'b0;
        exp_mis    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Sequential fetch with a response one cycle after each fire
        step(1, 0, 0, '0);
        repeat (4) step(1, 1, 0, '0);
        repeat (3) step(0, 1, 0, '0);

        // No responses: fill to the limit, then free one slot
        repeat (4) step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        step(1, 0, 0, '0);

        // Jump with two in flight, drain stale, first live fetch at target
        step(0, 0, 1, 32'h8000_1000);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);

        // Jump + fire + response together with one in flight
        step(1, 0, 0, '0);
        step(1, 1, 1, 32'h8000_2000);
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(0, 1, 0, '0);

        // Misaligned target
        step(0, 0, 1, 32'h8000_0406);
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);

        // Reset in the middle of a drain
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 1, 32'h8000_3000);
        step(0, 1, 0, '0);
        do_reset();

        // Jump during BOOT, then wrap across 2^32
        step(0, 0, 1, 32'hFFFF_FFF8);
        step(1, 0, 0, '0);
        step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);

        // Randomized traffic with occasional jumps
        for (int n = 0; n < 120; n++)
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, $urandom());
        repeat (4) step(0, 1, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
